// File: rtl/score_target_controller.sv
// Target-digit controller: detects ball/target overlap, scores the hit at
// the frame boundary, blanks the target for a cooldown, then picks a new one.
// Ports: clk, reset (sync, active-high), startOfFrame, drawBall,
//   drawScoreNumber, clearScore -> scoreNumber[3:0], score[9:0],
//   hitPulse, armed.
module score_target_controller #(
  parameter int unsigned HIT_POINTS      = 1,
  parameter int unsigned SCORE_MAX       = 999,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter logic [3:0]  INITIAL_TARGET  = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       drawBall,
  input  logic       drawScoreNumber,
  input  logic       clearScore,
  output logic [3:0] scoreNumber,
  output logic [9:0] score,
  output logic       hitPulse,
  output logic       armed
);

  localparam int CDW =
    (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CDW-1:0] CD_LOAD = CDW'(COOLDOWN_FRAMES);
  localparam logic [CDW-1:0] CD_ONE  = CDW'(1);
  localparam logic [10:0]    ADD_PTS = 11'(HIT_POINTS);
  localparam logic [10:0]    CAP     = 11'(SCORE_MAX);
  localparam logic [3:0]     BLANK   = 4'hF;

  typedef enum logic [1:0] {
    ARMED,
    HIT,
    COOLDOWN
  } state_t;

  state_t         state_q, state_d;
  logic [9:0]     score_q, score_d;
  logic [3:0]     num_q, num_d;
  logic [3:0]     tgt_q, tgt_d;
  logic [3:0]     nxt_q, nxt_d;
  logic           hit_q, hit_d;
  logic           armed_q, armed_d;
  logic [CDW-1:0] cd_q, cd_d;
  logic [7:0]     lfsr_q, lfsr_d;

  logic        coinc;
  logic        score_evt;
  logic [3:0]  cand;
  logic [3:0]  pick;
  logic [10:0] sum;
  logic [10:0] sat;

  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // fold 10..15 onto 4..9, then step past the current target
    cand = lfsr_q[3:0];
    if (cand > 4'd9) cand = cand - 4'd6;
    pick = cand;
    if (cand == tgt_q)
      pick = (tgt_q == 4'd9) ? 4'd0 : tgt_q + 4'd1;

    sum = {1'b0, score_q} + ADD_PTS;
    sat = (sum > CAP) ? CAP : sum;

    coinc = drawBall & drawScoreNumber;
    // a coincidence on the boundary cycle belongs to the closing frame
    score_evt = startOfFrame &
                ((state_q == HIT) |
                 ((state_q == ARMED) & coinc));

    state_d = state_q;
    score_d = score_q;
    num_d   = num_q;
    tgt_d   = tgt_q;
    nxt_d   = nxt_q;
    cd_d    = cd_q;
    hit_d   = 1'b0;

    unique case (state_q)
      ARMED: begin
        if (coinc && !startOfFrame) state_d = HIT;
      end
      HIT: begin
      end
      COOLDOWN: begin
        if (startOfFrame) begin
          if (cd_q <= CD_ONE) begin
            cd_d    = '0;
            state_d = ARMED;
            num_d   = nxt_q;
            tgt_d   = nxt_q;
          end else begin
            cd_d = cd_q - CD_ONE;
          end
        end
      end
      default: state_d = ARMED;
    endcase

    if (score_evt) begin
      hit_d   = 1'b1;
      score_d = sat[9:0];
      if (COOLDOWN_FRAMES == 0) begin
        state_d = ARMED;
        num_d   = pick;
        tgt_d   = pick;
      end else begin
        state_d = COOLDOWN;
        cd_d    = CD_LOAD;
        nxt_d   = pick;
        num_d   = BLANK;
      end
    end

    if (clearScore) score_d = '0;

    armed_d = (state_d != COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARMED;
      score_q <= '0;
      num_q   <= INITIAL_TARGET;
      tgt_q   <= INITIAL_TARGET;
      nxt_q   <= INITIAL_TARGET;
      hit_q   <= 1'b0;
      armed_q <= 1'b1;
      cd_q    <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      num_q   <= num_d;
      tgt_q   <= tgt_d;
      nxt_q   <= nxt_d;
      hit_q   <= hit_d;
      armed_q <= armed_d;
      cd_q    <= cd_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign scoreNumber = num_q;
  assign score       = score_q;
  assign hitPulse    = hit_q;
  assign armed       = armed_q;

endmodule

// File: tb/tb_score_target_controller.sv
// Directed bench for score_target_controller: two instances
// (cooldown 2 and cooldown 0) driven from a shared stimulus.
module tb_score_target_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sof = 1'b0;
  logic       ball = 1'b0;
  logic       dsn = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] a_num, b_num;
  logic [9:0] a_score, b_score;
  logic       a_hit, b_hit, a_armed, b_armed;

  int checks = 0;
  int errors = 0;
  int hits_a, hits_b;
  logic [7:0] m_lfsr;
  logic [3:0] exp_next, cur, exp_t;

  always #5 clk = ~clk;

  score_target_controller #(
    .COOLDOWN_FRAMES(2),
    .INITIAL_TARGET(4'd3)
  ) u_a (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .drawBall(ball), .drawScoreNumber(dsn),
    .clearScore(clr), .scoreNumber(a_num),
    .score(a_score), .hitPulse(a_hit), .armed(a_armed)
  );

  score_target_controller #(
    .COOLDOWN_FRAMES(0),
    .INITIAL_TARGET(4'd3)
  ) u_b (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .drawBall(ball), .drawScoreNumber(dsn),
    .clearScore(clr), .scoreNumber(b_num),
    .score(b_score), .hitPulse(b_hit), .armed(b_armed)
  );

  // reference LFSR: x^8+x^6+x^5+x^4+1, shift left
  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0],
                    m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] map_t(input logic [7:0] l,
                                       input logic [3:0] t);
    logic [3:0] c;
    c = l[3:0];
    if (c > 4'd9) c = c - 4'd6;
    if (c == t) c = (t == 4'd9) ? 4'd0 : t + 4'd1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_hit) hits_a++;
    if (b_hit) hits_b++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cd_frame();
    ball = 1'b1; dsn = 1'b1;
    repeat (8) tick();
    ball = 1'b0; dsn = 1'b0;
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  initial begin
    hits_a = 0; hits_b = 0;
    #2;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_num", a_num, 4'd3);
    check("rst_score", a_score, 0);
    check("rst_hit", a_hit, 0);
    check("rst_armed", a_armed, 1);

    // five idle frames
    hits_a = 0; hits_b = 0;
    repeat (5) begin
      sof = 1'b1; tick(); sof = 1'b0;
      repeat (9) tick();
    end
    check("idle_num", a_num, 4'd3);
    check("idle_score", a_score, 0);
    check("idle_hits", hits_a, 0);
    check("idle_armed", a_armed, 1);

    // long coincidence, scored once at the boundary
    ball = 1'b1; dsn = 1'b1;
    hits_a = 0;
    repeat (40) tick();
    check("mid_no_hit", hits_a, 0);
    ball = 1'b0; dsn = 1'b0;
    exp_next = map_t(m_lfsr, 4'd3);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    check("hit_pulse", a_hit, 1);
    check("hit_score", a_score, 1);
    check("hit_blank", a_num, 4'hF);
    check("hit_armed", a_armed, 0);
    check("cd0_num", b_num, exp_next);
    check("cd0_hit", b_hit, 1);
    tick();
    check("pulse_once", a_hit, 0);

    // cooldown of two frames with injected coincidences
    hits_a = 0;
    cd_frame();
    check("cd1_blank", a_num, 4'hF);
    check("cd1_armed", a_armed, 0);
    cd_frame();
    check("cd2_num", a_num, exp_next);
    check("cd2_diff", a_num != 4'd3, 1);
    check("cd2_range", a_num <= 4'd9, 1);
    check("cd2_armed", a_armed, 1);
    check("cd_score", a_score, 1);
    check("cd_hits", hits_a, 0);

    // coincidence only on the boundary cycle
    reset = 1'b1; tick(); reset = 1'b0;
    ball = 1'b1; dsn = 1'b1; sof = 1'b1;
    tick();
    ball = 1'b0; dsn = 1'b0; sof = 1'b0;
    check("sof_only_score", a_score, 1);
    check("sof_only_hit", a_hit, 1);

    // reset in the middle of cooldown
    repeat (3) tick();
    check("pre_rst_blank", a_num, 4'hF);
    reset = 1'b1; tick(); reset = 1'b0;
    check("cd_rst_num", a_num, 4'd3);
    check("cd_rst_score", a_score, 0);
    check("cd_rst_armed", a_armed, 1);

    // 200 back-to-back hits without cooldown
    cur = 4'd3;
    for (int i = 0; i < 200; i++) begin
      exp_t = map_t(m_lfsr, cur);
      ball = 1'b1; dsn = 1'b1; sof = 1'b1;
      tick();
      check("seq_num", b_num, exp_t);
      check("seq_diff", b_num != cur, 1);
      cur = exp_t;
    end
    check("seq_score", b_score, 200);

    // saturation
    repeat (798) tick();
    check("pre_sat", b_score, 998);
    tick();
    check("sat1_score", b_score, 999);
    check("sat1_hit", b_hit, 1);
    tick();
    check("sat2_score", b_score, 999);
    check("sat2_hit", b_hit, 1);
    ball = 1'b0; dsn = 1'b0; sof = 1'b0;
    clr = 1'b1;
    tick();
    check("clr_score", b_score, 0);
    check("clr_nohit", b_hit, 0);
    clr = 1'b0;
    tick();
    check("clr_hold", b_score, 0);

    // clear coinciding with a scored boundary
    ball = 1'b1; dsn = 1'b1; sof = 1'b1; clr = 1'b1;
    tick();
    ball = 1'b0; dsn = 1'b0; sof = 1'b0; clr = 1'b0;
    check("clr_hit_score", b_score, 0);
    check("clr_hit_pulse", b_hit, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
